// File: rtl/fau_expand.sv
// rtl/fau_expand.sv - streaming unpacker from packed 8-bit codes to 32-bit accumulator values
//
// Accepts one LANES-wide packed word per input handshake and emits one expanded
// lane per output handshake, lane 0 first. The format is latched with the word.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    packed word handshake
//   in_data              LANES packed codes, lane k = in_data[k*W +: W]
//   fp_src               format: 0x unsigned, 10 signed << 17, 11 signed << 19
//   out_valid/out_ready  expanded value handshake
//   out_data             expanded 32-bit value
//   out_last             marks the final lane of a word
module fau_expand #(
   parameter int W     = 8,
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_data,
   input  logic [1:0]         fp_src,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic               out_last
);

   localparam int LW = $clog2(LANES);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [LANES*W-1:0] buf_q, buf_d;
   logic [1:0]         fmt_q, fmt_d;
   logic [LW-1:0]      lane_q, lane_d;

   logic               emit;
   logic               is_last;
   logic               load;
   logic [W-1:0]       code;
   logic [31:0]        expanded;

   assign emit    = (state_q == S_EMIT);
   assign is_last = (lane_q == LW'(LANES - 1));

   // The last lane being consumed frees the buffer in the same cycle, which is
   // what lets back-to-back words stream without a bubble.
   assign in_ready = !emit || (is_last && out_ready);
   assign load     = in_valid && in_ready;

   always_comb begin
      code = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_q == LW'(k)) begin
            code = buf_q[k*W +: W];
         end
      end
   end

   // Signed formats keep bit 7 as the sign and replicate it above the
   // magnitude bits, i.e. sign_extend(code) shifted left.
   always_comb begin
      case (fmt_q)
         2'b10:   expanded = {{8{code[7]}}, code[6:0], 17'b0};
         2'b11:   expanded = {{6{code[7]}}, code[6:0], 19'b0};
         default: expanded = {8'h00, code, 16'h0000};
      endcase
   end

   assign out_valid = emit;
   assign out_last  = emit && is_last;
   assign out_data  = emit ? expanded : 32'h0;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      fmt_d   = fmt_q;
      lane_d  = lane_q;
      if (load) begin
         buf_d   = in_data;
         fmt_d   = fp_src;
         lane_d  = '0;
         state_d = S_EMIT;
      end else if (emit && out_ready) begin
         if (is_last) begin
            state_d = S_IDLE;
            lane_d  = '0;
         end else begin
            lane_d = lane_q + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         fmt_q   <= 2'b00;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fmt_q   <= fmt_d;
         lane_q  <= lane_d;
      end
   end

endmodule
